// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants, width derivation and parameter checks for seq_det_prog
package seq_det_pkg;
  localparam logic [31:0] RST_PAT = 32'b1010;
  localparam int RST_LEN = 4;
  localparam logic RST_OVL = 1'b0;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  function automatic bit max_len_ok(input int v);
    return v >= 4 && v <= 32;
  endfunction
  function automatic bit cnt_w_ok(input int v);
    return v >= 2 && v <= 32;
  endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial stream, configuration and status bundle of the sequence detector
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = len_w(MAX_LEN);
  logic In;
  logic In_Vld;
  logic Cfg_Load;
  logic [MAX_LEN-1:0] Cfg_Pattern;
  logic [LEN_W-1:0] Cfg_Len;
  logic Cfg_Overlap;
  logic Cnt_Clr;
  logic OP;
  logic [CNT_W-1:0] Match_Cnt;
  logic Cfg_Err;
  modport master (
    output In, In_Vld, Cfg_Load, Cfg_Pattern, Cfg_Len, Cfg_Overlap, Cnt_Clr,
    input OP, Match_Cnt, Cfg_Err
  );
  modport slave (
    input In, In_Vld, Cfg_Load, Cfg_Pattern, Cfg_Len, Cfg_Overlap, Cnt_Clr,
    output OP, Match_Cnt, Cfg_Err
  );
endinterface

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating match counter; a clear coinciding with an increment yields 1
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // next count: clear wins but still records a same-cycle increment, otherwise saturate at all-ones
  always_comb cnt_d = clr ? CNT_W'(inc) : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable-pattern Mealy sequence detector with overlap mode and match counter
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8
) (
  input logic Clk,
  input logic Rst,
  seq_det_if.slave bus
);
  localparam int LEN_W = len_w(MAX_LEN);
  if (!max_len_ok(MAX_LEN)) begin : g_bad_max_len
    $error("seq_det_prog: MAX_LEN must be within 4..32");
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
    $error("seq_det_prog: CNT_W must be within 2..32");
  end
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic ovl_q, ovl_d, err_q, err_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] win, diff;
  logic fill_ok, accept, match, bad_len;
  // the oldest history bit can never reach a compare window, so only MAX_LEN-1 bits are kept
  assign win = {hist_q, bus.In};
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign diff[i] = (LEN_W'(i) < len_q) & (win[i] ^ pat_q[i]);
  end
  assign fill_ok = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
  assign accept = bus.In_Vld & ~bus.Cfg_Load & ~Rst;
  assign match = accept & ~err_q & fill_ok & ~|diff;
  assign bad_len = bus.Cfg_Len == '0 || bus.Cfg_Len > LEN_W'(MAX_LEN);
  assign bus.OP = match;
  assign bus.Cfg_Err = err_q;
  // next config and detector state: a load restarts detection, an accepted bit shifts in
  always_comb begin
    pat_d = bus.Cfg_Load ? bus.Cfg_Pattern : pat_q;
    len_d = bus.Cfg_Load ? bus.Cfg_Len : len_q;
    ovl_d = bus.Cfg_Load ? bus.Cfg_Overlap : ovl_q;
    err_d = bus.Cfg_Load ? bad_len : err_q;
    hist_d = bus.Cfg_Load ? '0 : accept ? win[MAX_LEN-2:0] : hist_q;
    fill_d = bus.Cfg_Load ? '0 : !accept ? fill_q : (match && !ovl_q) ? '0 :
             fill_q == LEN_W'(MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
  end
  // state registers; reset restores the default 1010 non-overlapping pattern
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pat_q <= MAX_LEN'(RST_PAT);
      len_q <= LEN_W'(RST_LEN);
      ovl_q <= RST_OVL;
      err_q <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      err_q <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
  seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(Clk),
    .rst(Rst),
    .clr(bus.Cnt_Clr),
    .inc(match),
    .cnt(bus.Match_Cnt)
  );
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed scoreboard bench for seq_det_prog (8-bit and 2-bit counter builds)
module tb_seq_det_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  logic exp_q[$];
  always #5 clk = ~clk;
  seq_det_if #(.MAX_LEN(8), .CNT_W(8)) a_if();
  seq_det_if #(.MAX_LEN(8), .CNT_W(2)) b_if();
  assign b_if.In = a_if.In;
  assign b_if.In_Vld = a_if.In_Vld;
  assign b_if.Cfg_Load = a_if.Cfg_Load;
  assign b_if.Cfg_Pattern = a_if.Cfg_Pattern;
  assign b_if.Cfg_Len = a_if.Cfg_Len;
  assign b_if.Cfg_Overlap = a_if.Cfg_Overlap;
  assign b_if.Cnt_Clr = a_if.Cnt_Clr;
  seq_det_prog #(.MAX_LEN(8), .CNT_W(8)) u_a (.Clk(clk), .Rst(rst), .bus(a_if.slave));
  seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) u_b (.Clk(clk), .Rst(rst), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("cnt_a", 32'(a_if.Match_Cnt), 32'(cnt_a));
    chk("cnt_b", 32'(b_if.Match_Cnt), 32'(cnt_b));
  endtask

  task automatic step(input logic b, input logic vld, input logic ex, input logic clr);
    logic e;
    a_if.In = b;
    a_if.In_Vld = vld;
    a_if.Cnt_Clr = clr;
    exp_q.push_back(ex);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("op_a", 32'(a_if.OP), 32'(e));
    chk("op_b", 32'(b_if.OP), 32'(e));
    if (clr) begin
      cnt_a = int'(e);
      cnt_b = int'(e);
    end else if (e) begin
      cnt_a = cnt_a < 255 ? cnt_a + 1 : 255;
      cnt_b = cnt_b < 3 ? cnt_b + 1 : 3;
    end
    @(posedge clk);
    #1;
    a_if.In_Vld = 1'b0;
    a_if.Cnt_Clr = 1'b0;
    chk_cnt();
  endtask

  task automatic run(input logic [15:0] bits, input logic [15:0] ex, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ex[i], 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    a_if.Cfg_Load = 1'b1;
    a_if.Cfg_Pattern = pat;
    a_if.Cfg_Len = len;
    a_if.Cfg_Overlap = ovl;
    a_if.In = 1'b0;
    a_if.In_Vld = 1'b1;
    @(negedge clk);
    chk("load_op_a", 32'(a_if.OP), 32'd0);
    chk("load_op_b", 32'(b_if.OP), 32'd0);
    @(posedge clk);
    #1;
    a_if.Cfg_Load = 1'b0;
    a_if.In_Vld = 1'b0;
    chk("cfg_err", 32'(a_if.Cfg_Err), 32'(len == 4'd0 || len > 4'd8));
    chk_cnt();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_if.In = 1'b0;
    a_if.In_Vld = 1'b1;
    @(negedge clk);
    chk("rst_op_a", 32'(a_if.OP), 32'd0);
    chk("rst_op_b", 32'(b_if.OP), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_if.In_Vld = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    chk_cnt();
    chk("rst_err", 32'(a_if.Cfg_Err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.In = 1'b0;
    a_if.In_Vld = 1'b0;
    a_if.Cfg_Load = 1'b0;
    a_if.Cfg_Pattern = '0;
    a_if.Cfg_Len = '0;
    a_if.Cfg_Overlap = 1'b0;
    a_if.Cnt_Clr = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run(16'b1010101010, 16'b0001000100, 10);
    load(8'b1010, 4'd4, 1'b1);
    run(16'b1010101010, 16'b0001010101, 10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    load(8'b111, 4'd3, 1'b1);
    run(16'b11111, 16'b00111, 5);
    load(8'b111, 4'd3, 1'b0);
    run(16'b111111, 16'b001001, 6);
    load(8'b1010, 4'd4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run(16'b101, 16'b000, 3);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run(16'b1010, 16'b0001, 4);
    load(8'b1010, 4'd0, 1'b0);
    run(16'b10101010, 16'b0, 8);
    load(8'b1010, 4'd9, 1'b0);
    run(16'b10101010, 16'b0, 8);
    load(8'b1, 4'd1, 1'b0);
    run(16'b101, 16'b101, 3);
    load(8'b10110011, 4'd8, 1'b0);
    run(16'b1011001101, 16'b0000000100, 10);
    load(8'b1010, 4'd4, 1'b0);
    run(16'b0, 16'b0, 12);
    run(16'b1010, 16'b0001, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Programmable-pattern Mealy sequence detector, the parametrised successor of the fixed 4-bit "1010" detectors in the FSM collection. Pattern bits, pattern length (1..MAX_LEN) and overlap/non-overlap mode are runtime-loadable. A saturating match counter is included. It sits directly on a serial bit stream with a per-bit valid qualifier and drives a combinational Mealy match flag.

## Interface
- MAX_LEN, 8, maximum pattern length; legal range 4..32
- CNT_W, 8, match counter width; legal range 2..32
- LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridable)
- Clk  in  1  sole clock, rising edge
- Rst  in  1  synchronous, active-high reset
- In  in  1  serial data bit
- In_Vld  in  1  In is a valid stream bit this cycle
- Cfg_Load  in  1  latch Cfg_Pattern, Cfg_Len and Cfg_Overlap
- Cfg_Pattern  in  MAX_LEN  pattern; the first-received bit is Cfg_Pattern[Cfg_Len-1] and the last is Cfg_Pattern[0]
- Cfg_Len  in  LEN_W  pattern length
- Cfg_Overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- Cnt_Clr  in  1  clear the match counter
- OP  out  1  Mealy match flag (combinational)
- Match_Cnt  out  CNT_W  saturating count of matches (registered)
- Cfg_Err  out  1  the active Cfg_Len is 0 or greater than MAX_LEN; the detector is disabled (registered)

## Operation
- Active config registers: pat, len, ovl.
  - Reset values: pat = 'b1010 (zero-extended), len = 4, ovl = 0, Cfg_Err = 0.
- Detector state:
  - hist[MAX_LEN-1:0]: hist[0] holds the newest accepted bit.
  - fill: count of bits accepted since the last restart, saturating at MAX_LEN.
- Match condition (combinational), all of the following must hold:
  - In_Vld = 1, Cfg_Load = 0, Rst = 0 and Cfg_Err = 0;
  - fill ≥ len-1;
  - {hist[len-2:0], In} equals pat[len-1:0]. For len = 1, only In == pat[0] is compared.
- OP = match condition.
- On an accepted bit (In_Vld = 1, no load, no reset):
  - hist shifts left with In entering at bit 0.
  - If match and ovl = 0: fill ← 0.
  - Otherwise: fill ← min(fill+1, MAX_LEN).
  - If match and ovl = 1: fill keeps incrementing, so the pattern tail can begin the next match.
- In_Vld = 0: hist and fill hold and OP = 0. Gaps do not break a partial sequence.
- Cfg_Load = 1:
  - Latches pat, len and ovl.
  - Sets Cfg_Err if Cfg_Len is 0 or greater than MAX_LEN.
  - Clears hist and fill.
  - In is ignored that cycle and OP = 0.
  - Match_Cnt is unaffected.
- Match_Cnt:
  - Increments on each match and saturates at 2^CNT_W-1.
  - If Cnt_Clr and a match occur in the same cycle, Match_Cnt ← 1.
  - Cnt_Clr alone sets Match_Cnt ← 0.
- Priority: Rst > Cfg_Load > accepted bit.

## Timing
- OP has zero-cycle latency: it is valid in the same cycle as the final pattern bit. It is combinational from In, In_Vld and Cfg_Load.
- Match_Cnt, hist and fill update on the Clk edge that ends the matching cycle.
- Rst (synchronous):
  - On the next edge: hist = 0, fill = 0, Match_Cnt = 0, Cfg_Err = 0, and the config returns to its reset values.
  - While Rst is high, OP = 0.
- Rst mid-sequence discards the partial sequence; no match may use bits accepted before the reset.
- A new configuration applies to bits arriving in the cycle after Cfg_Load.
- fill saturation at MAX_LEN must not suppress later matches.

## Structure
- Package seq_det_pkg holds:
  - the reset-pattern constants RST_PAT = 'b1010, RST_LEN = 4, RST_OVL = 0;
  - the LEN_W derivation function;
  - parameter-range checks, which raise an elaboration error on an illegal MAX_LEN or CNT_W.
- Sub-module seq_det_sat_cnt implements the saturating counter with clear and increment inputs and the clear-plus-increment = 1 rule. It is parametrised by CNT_W.
- Top level: config registers, hist/fill datapath, masked compare (a variable-length window compare generated over MAX_LEN), and the OP logic.

## Test plan
- Reset defaults, In_Vld held at 1, stream 1010101010 (left bit first) → OP = 1 on bits 4 and 8 only; Match_Cnt = 2.
- Load pat = 1010, len = 4, ovl = 1; same stream → OP on bits 4, 6, 8 and 10; Match_Cnt = 4.
- Load pat = 111, len = 3, stream 11111:
  - ovl = 1 → OP on bits 3, 4 and 5;
  - ovl = 0 → OP on bit 3 only, then on bit 6 when a sixth 1 is sent.
- Default config, bits 1, 0, 1 sent with two In_Vld = 0 cycles between each, then 0 → OP only on the final 0.
- Robustness:
  - Rst asserted after bits 101, then 0 → no OP.
  - Cfg_Len = 0 → Cfg_Err = 1 and OP is never asserted.
  - MAX_LEN = 8, Cfg_Len = 8, pattern 10110011 → OP on bit 8 only.
- CNT_W = 2, repeated matches → Match_Cnt saturates at 3. Cnt_Clr in the same cycle as a match → 1; Cnt_Clr alone → 0.
